program_memory_loader: RTL and testbench

Byte-stream loader that fills the writable program memory before the MIPS core runs. It accepts a framed byte stream (word count, instruction words, checksum), assembles big-endian 32-bit instructions, and issues one write per word at word-aligned byte addresses 0, 4, 8, …. These are the same byte addresses the fetch path presents to program memory, which drops Address[1:0] internally. While loading it holds the core off via Busy, then reports Load_Done or Error.

---
 rtl/program_memory_loader.sv | 170 +++++++++++++++++
 tb/tb_program_memory_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_loader.sv
// program_memory_loader
// Fills the writable program memory from a framed byte stream before the core
// runs. Frame: COUNT_HI, COUNT_LO (word count N), 4*N data bytes (each word
// MSB first), CHK (XOR of the data bytes). One write per word, at byte
// address 4*k.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Start             begin a load (honoured in IDLE, DONE, ERROR)
//   Byte_In/Valid     stream byte, consumed when Byte_Valid && Byte_Ready
//   Byte_Ready        loader accepts a byte this cycle
//   Write_Enable      one-cycle write strobe
//   Write_Address     word-aligned byte address of the write
//   Write_Data        assembled big-endian instruction word
//   Busy              load in progress (holds the core in reset)
//   Load_Done, Error  sticky result of the last load
module program_memory_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [7:0]            Byte_In,
  input  logic                  Byte_Valid,
  output logic                  Byte_Ready,
  output logic                  Write_Enable,
  output logic [DATA_WIDTH-1:0] Write_Address,
  output logic [DATA_WIDTH-1:0] Write_Data,
  output logic                  Busy,
  output logic                  Load_Done,
  output logic                  Error
);

  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MEMORY_DEPTH);

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      widx_q, widx_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            chk_q, chk_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic [CNT_W-1:0]      n_hdr;

  // Byte_Ready is a registered decode of the framing states, so it gates acceptance
  assign accept = Byte_Valid && ready_q;
  assign n_hdr  = {count_q[15:8], Byte_In};

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    chk_d   = chk_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_HDR_HI;
          count_d = '0;
          widx_d  = '0;
          bcnt_d  = '0;
          word_d  = '0;
          chk_d   = '0;
        end
      end
      S_HDR_HI: begin
        if (accept) begin
          count_d = {Byte_In, 8'h00};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          count_d = n_hdr;
          if (n_hdr > DEPTH)           state_d = S_ERROR;
          else if (n_hdr == '0)        state_d = S_CHECK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d  = chk_q ^ Byte_In;
          bcnt_d = bcnt_q + 2'd1;
          word_d = {word_q[15:0], Byte_In};
          // Fourth byte completes the word: issue the write next cycle
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = DATA_WIDTH'({widx_q, 2'b00});
            data_d = DATA_WIDTH'({word_q, Byte_In});
            widx_d = widx_q + CNT_W'(1);
            if (widx_q == CNT_W'(count_q - CNT_W'(1))) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (Byte_In == chk_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they track state_q exactly
  always_comb begin
    ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
              (state_d == S_DATA)   || (state_d == S_CHECK);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERROR);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      widx_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      chk_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      chk_q   <= chk_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Byte_Ready    = ready_q;
  assign Busy          = ready_q;
  assign Write_Enable  = we_q;
  assign Write_Address = addr_q;
  assign Write_Data    = data_q;
  assign Load_Done     = done_q;
  assign Error         = err_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Testbench for program_memory_loader: directed frames plus randomized frames
// checked against a frame-level reference model (expected writes and result).
module tb_program_memory_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic        Write_Enable;
  logic [31:0] Write_Address;
  logic [31:0] Write_Data;
  logic        Busy;
  logic        Load_Done;
  logic        Error;

  program_memory_loader #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Byte_In(Byte_In),
    .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Write_Enable(Write_Enable), .Write_Address(Write_Address),
    .Write_Data(Write_Data), .Busy(Busy), .Load_Done(Load_Done), .Error(Error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  int vectors     = 0;
  int miscompares = 0;
  int valid_pct   = 100;
  bit chaos_start = 1'b0;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];

  // Collect every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (Write_Enable === 1'b1) begin
      got_a.push_back(Write_Address);
      got_d.push_back(Write_Data);
    end
  end

  // Reference model: frame bytes for a word list; checksum optionally corrupted
  function automatic void model_frame(input wq_t words, input logic [7:0] chk_xor,
                                      output bq_t frame);
    logic [7:0]  chk;
    logic [15:0] n;
    logic [31:0] w;
    chk = 8'h00;
    n = 16'(words.size());
    frame = {};
    frame.push_back(n[15:8]);
    frame.push_back(n[7:0]);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int b = 3; b >= 0; b--) begin
        frame.push_back(w[8*b +: 8]);
        chk = chk ^ w[8*b +: 8];
      end
    end
    frame.push_back(chk ^ chk_xor);
  endfunction

  // All drivers start and end just after a rising edge
  task automatic start_pulse();
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    bit done;
    int guard;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin
      Byte_In    = b;
      Byte_Valid = ($urandom_range(99) < valid_pct);
      Start      = chaos_start && ($urandom_range(1) == 1);
      done       = Byte_Valid && Byte_Ready;
      @(posedge clk); #1;
      guard++;
    end
    Byte_Valid = 1'b0;
    Start      = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drive_byte: byte %02h never accepted (Byte_Ready=%b)", b, Byte_Ready);
    end
  endtask

  task automatic run_frame(input bq_t frame);
    foreach (frame[i]) drive_byte(frame[i]);
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; Byte_Valid = 1'b0; Byte_In = 8'h00;
    #12;
    vectors++;
    if ({Byte_Ready, Write_Enable, Busy, Load_Done, Error, Write_Address, Write_Data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b err=%b a=%h d=%h, want all 0",
               Byte_Ready, Write_Enable, Busy, Load_Done, Error, Write_Address, Write_Data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    // Bytes offered while idle must be ignored
    Byte_Valid = 1'b1; Byte_In = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    Byte_Valid = 1'b0;
    vectors++;
    if ({Byte_Ready, Busy, got_a.size() != 0} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_ignore: rdy=%b busy=%b writes=%0d, want 0 0 0", Byte_Ready, Busy, got_a.size());
    end
  endtask

  task automatic test_n2_frame(input logic [7:0] chk, input bit exp_ok, input string tag);
    logic [7:0]  fr_arr[11];
    logic [31:0] exp_a[2];
    logic [31:0] exp_d[2];
    fr_arr = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, chk};
    exp_a  = '{32'h0, 32'h4};
    exp_d  = '{32'h24080005, 32'h8C090004};
    valid_pct = 100; chaos_start = 1'b0;
    got_a = {}; got_d = {};
    start_pulse();
    vectors++;
    if ({Busy, Byte_Ready, Load_Done, Error} !== 4'b1100) begin
      miscompares++;
      $display("FAIL %s start: busy=%b rdy=%b done=%b err=%b, want 1 1 0 0", tag, Busy, Byte_Ready, Load_Done, Error);
    end
    for (int i = 0; i < 10; i++) drive_byte(fr_arr[i]);
    // Final word strobe lands in the first CHECK cycle
    vectors++;
    if ({Write_Enable, Byte_Ready} !== 2'b11 || Write_Address !== 32'h4 || Write_Data !== 32'h8C090004) begin
      miscompares++;
      $display("FAIL %s last_write: we=%b rdy=%b a=%h d=%h, want 1 1 00000004 8c090004",
               tag, Write_Enable, Byte_Ready, Write_Address, Write_Data);
    end
    drive_byte(fr_arr[10]);
    vectors++;
    if ({Busy, Byte_Ready, Load_Done, Error} !== {2'b00, exp_ok, !exp_ok}) begin
      miscompares++;
      $display("FAIL %s result: busy=%b rdy=%b done=%b err=%b, want 0 0 %b %b",
               tag, Busy, Byte_Ready, Load_Done, Error, exp_ok, !exp_ok);
    end
    @(posedge clk); #1;
    vectors++;
    if (got_a.size() != 2) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d, want 2", tag, got_a.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL %s write%0d: got %h@%h, want %h@%h", tag, i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_oversize();
    valid_pct = 100; chaos_start = 1'b0;
    got_a = {}; got_d = {};
    start_pulse();
    drive_byte(8'h00);
    drive_byte(8'h21);
    vectors++;
    if ({Error, Load_Done, Busy, Byte_Ready, Write_Enable} !== 5'b10000) begin
      miscompares++;
      $display("FAIL oversize: err=%b done=%b busy=%b rdy=%b we=%b, want 1 0 0 0 0",
               Error, Load_Done, Busy, Byte_Ready, Write_Enable);
    end
    Byte_Valid = 1'b1; Byte_In = 8'h11;
    repeat (6) @(posedge clk);
    #1;
    Byte_Valid = 1'b0;
    vectors++;
    if (got_a.size() != 0 || Error !== 1'b1) begin
      miscompares++;
      $display("FAIL oversize_nowrite: writes=%0d err=%b, want 0 1", got_a.size(), Error);
    end
  endtask

  task automatic test_zero_count();
    bq_t frame;
    wq_t none;
    none = {};
    valid_pct = 100; chaos_start = 1'b0;
    got_a = {}; got_d = {};
    model_frame(none, 8'h00, frame);
    start_pulse();
    run_frame(frame);
    vectors++;
    if ({Load_Done, Error, Busy} !== 3'b100 || got_a.size() != 0) begin
      miscompares++;
      $display("FAIL zero_count: done=%b err=%b busy=%b writes=%0d, want 1 0 0 0",
               Load_Done, Error, Busy, got_a.size());
    end
    start_pulse();
    vectors++;
    if ({Load_Done, Busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL restart_clears: done=%b busy=%b, want 0 1", Load_Done, Busy);
    end
    run_frame(frame);
  endtask

  task automatic test_random_frame(input int n, input int pct, input bit chaos,
                                   input bit corrupt, input string tag);
    bq_t frame;
    wq_t words;
    logic [7:0] cx;
    words = {};
    for (int i = 0; i < n; i++) words.push_back($urandom);
    cx = corrupt ? 8'($urandom_range(1, 255)) : 8'h00;
    model_frame(words, cx, frame);
    got_a = {}; got_d = {};
    valid_pct = 100; chaos_start = 1'b0;
    start_pulse();
    valid_pct = pct; chaos_start = chaos;
    run_frame(frame);
    chaos_start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({Busy, Load_Done, Error} !== {1'b0, !corrupt, corrupt}) begin
      miscompares++;
      $display("FAIL %s result n=%0d: busy=%b done=%b err=%b, want 0 %b %b",
               tag, n, Busy, Load_Done, Error, !corrupt, corrupt);
    end
    vectors++;
    if (got_a.size() != n) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d, want %0d", tag, got_a.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        vectors++;
        if (got_a[i] !== 32'(4 * i) || got_d[i] !== words[i]) begin
          miscompares++;
          $display("FAIL %s write%0d: got %h@%h, want %h@%h", tag, i, got_d[i], got_a[i], words[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_full_depth();
    test_random_frame(32, 50, 1'b1, 1'b0, "full_depth");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++)
      test_random_frame(int'($urandom_range(1, 32)), 70, 1'b1, ($urandom_range(1) == 1), "rand_frame");
  endtask

  task automatic test_reset_mid_frame();
    bq_t frame;
    wq_t none;
    none = {};
    valid_pct = 100; chaos_start = 1'b0;
    got_a = {}; got_d = {};
    start_pulse();
    drive_byte(8'h00); drive_byte(8'h02);
    drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h78);
    drive_byte(8'h9A); drive_byte(8'hBC);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({Byte_Ready, Write_Enable, Busy, Load_Done, Error, Write_Address, Write_Data} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: rdy=%b we=%b busy=%b done=%b err=%b a=%h d=%h, want all 0",
               Byte_Ready, Write_Enable, Busy, Load_Done, Error, Write_Address, Write_Data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    Byte_Valid = 1'b1; Byte_In = 8'hDE;
    repeat (6) @(posedge clk);
    #1;
    Byte_Valid = 1'b0;
    vectors++;
    if (got_a.size() != 1 || got_a[0] !== 32'h0 || got_d[0] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL midreset_writes: count=%0d first=%h, want 1 write 12345678@0",
               got_a.size(), (got_d.size() > 0) ? got_d[0] : 32'hx);
    end
    vectors++;
    if ({Byte_Ready, Busy, Load_Done, Error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_idle: rdy=%b busy=%b done=%b err=%b, want 0 0 0 0",
               Byte_Ready, Busy, Load_Done, Error);
    end
    model_frame(none, 8'h00, frame);
    start_pulse();
    run_frame(frame);
    vectors++;
    if (Load_Done !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_recover: done=%b, want 1", Load_Done);
    end
  endtask

  initial begin
    test_reset();
    test_n2_frame(8'hA8, 1'b1, "n2_good");
    test_n2_frame(8'h0C, 1'b0, "n2_bad_0c");
    test_n2_frame(8'h0D, 1'b0, "n2_bad_0d");
    test_oversize();
    test_zero_count();
    test_full_depth();
    test_random_frames();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
